// File: rtl/user_input_pulse.sv
// -----------------------------------------------------------------------------
// user_input_pulse
//   Multi-channel conditioner for asynchronous push-buttons and switches.
//   Each channel runs the same chain, independently of the others:
//     synchroniser -> debouncer -> press FSM -> release detector.
//   The press FSM turns an accepted press into a single-cycle key_pulse.
//   The release detector turns an accepted release into a single-cycle
//   key_release.
//
//   Optional feature, selected by the macro USER_INPUT_REPEAT_EN:
//     defined   : a held key emits auto-repeat press pulses. The first repeat
//                 comes REPEAT_DELAY cycles after the press pulse; after that,
//                 one repeat every REPEAT_PERIOD cycles.
//     undefined : exactly one key_pulse per accepted press. REPEAT_* are
//                 ignored.
//
// Handshake: none. Every output is a free-running level or single-cycle strobe.
//
// Ports
//   clk          in   1    system clock, rising edge
//   rst          in   1    asynchronous reset, active low
//   key_in       in   N    raw asynchronous inputs, 1 = pressed
//   key_level    out  N    debounced level per channel
//   key_pulse    out  N    one-cycle pulse per accepted press (and each repeat)
//   key_release  out  N    one-cycle pulse per accepted release
//   key_any      out  1    OR of key_pulse
//   dbg_state    out  2*N  press FSM state per channel, bits [2*i+1:2*i]
//                          (0 = IDLE, 1 = PULSE, 2 = HELD)
// -----------------------------------------------------------------------------
module user_input_pulse #(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   key_in,
    output logic [N-1:0]   key_level,
    output logic [N-1:0]   key_pulse,
    output logic [N-1:0]   key_release,
    output logic           key_any,
    output logic [2*N-1:0] dbg_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HELD  = 2'd2
    } state_e;

    if (N < 1)               begin : g_bad_n   $error("N must be >= 1");               end
    if (SYNC_STAGES < 2)     begin : g_bad_s   $error("SYNC_STAGES must be >= 2");     end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_d   $error("DEBOUNCE_CYCLES must be >= 1"); end
    if (REPEAT_DELAY < 2)    begin : g_bad_rd  $error("REPEAT_DELAY must be >= 2");    end
    if (REPEAT_PERIOD < 2)   begin : g_bad_rp  $error("REPEAT_PERIOD must be >= 2");   end

    assign key_any = |key_pulse;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        logic                   stable_q, stable_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   stable_dly_q;
        logic                   release_q;
        state_e                 state_q, state_d;

        assign sync = sync_q[SYNC_STAGES-1];

        // Debouncer: any cycle in which sync agrees with stable restarts the
        // count. So only DEBOUNCE_CYCLES consecutive disagreeing cycles flip
        // stable.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = cnt_q;
            if (sync == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q       <= '0;
                stable_q     <= 1'b0;
                cnt_q        <= '0;
                stable_dly_q <= 1'b0;
                release_q    <= 1'b0;
                state_q      <= ST_IDLE;
            end else begin
                sync_q       <= {sync_q[SYNC_STAGES-2:0], key_in[g]};
                stable_q     <= stable_d;
                cnt_q        <= cnt_d;
                stable_dly_q <= stable_q;
                release_q    <= stable_dly_q & ~stable_q;
                state_q      <= state_d;
            end
        end

`ifdef USER_INPUT_REPEAT_EN
        localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;

        logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
        logic             first_q, first_d;
        logic [REP_W-1:0] rep_last;

        // rep_cnt is cleared on every entry to HELD, so it counts up from 0
        // and the PULSE cycle plus the clear cycle complete the interval.
        assign rep_last = first_q ? REP_W'(REPEAT_DELAY - 2) : REP_W'(REPEAT_PERIOD - 2);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rep_cnt_q <= '0;
                first_q   <= 1'b0;
            end else begin
                rep_cnt_q <= rep_cnt_d;
                first_q   <= first_d;
            end
        end
`endif

        always_comb begin
            state_d = state_q;
`ifdef USER_INPUT_REPEAT_EN
            rep_cnt_d = rep_cnt_q;
            first_d   = first_q;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (stable_q) begin
                        state_d = ST_PULSE;
`ifdef USER_INPUT_REPEAT_EN
                        first_d = 1'b1;
`endif
                    end
                end
                ST_PULSE: begin
                    if (stable_q) begin
                        state_d = ST_HELD;
`ifdef USER_INPUT_REPEAT_EN
                        rep_cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (!stable_q) begin
                        state_d = ST_IDLE;
                    end
`ifdef USER_INPUT_REPEAT_EN
                    else if (rep_cnt_q == rep_last) begin
                        state_d = ST_PULSE;
                        first_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end

        assign key_level[g]       = stable_q;
        assign key_pulse[g]       = (state_q == ST_PULSE);
        assign key_release[g]     = release_q;
        assign dbg_state[2*g +: 2] = state_q;
    end

endmodule

// File: tb/tb_user_input_pulse.sv
module tb_user_input_pulse;

    localparam int N = 4;

`ifdef USER_INPUT_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   key_in;
    logic [N-1:0]   key_level;
    logic [N-1:0]   key_pulse;
    logic [N-1:0]   key_release;
    logic           key_any;
    logic [2*N-1:0] dbg_state;

    always #5 clk = ~clk;

    user_input_pulse #(
        .N               (N),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_pulse   (key_pulse),
        .key_release (key_release),
        .key_any     (key_any),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: inputs changed and outputs sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int w_pulse_cnt, w_first_pulse, w_rel_cnt, w_first_rel;
    int w_rise, w_fall, w_any_cnt, w_any_mis, w_late_pulse;

    // Watches channel ch for len cycles. Tick numbers start at 1. Tick k is
    // the sample taken just after the k-th rising edge from the start of
    // the window.
    task automatic watch(input int len, input int ch);
        logic prev;
        w_pulse_cnt = 0; w_first_pulse = -1; w_rel_cnt = 0; w_first_rel = -1;
        w_rise = -1; w_fall = -1; w_any_cnt = 0; w_any_mis = 0; w_late_pulse = 0;
        got_q.delete();
        prev = key_level[ch];
        for (int i = 1; i <= len; i++) begin
            tick();
            if (key_pulse[ch]) begin
                w_pulse_cnt++;
                got_q.push_back(32'(i));
                if (w_first_pulse < 0) w_first_pulse = i;
                if (w_fall >= 0) w_late_pulse++;
            end
            if (key_release[ch]) begin
                w_rel_cnt++;
                if (w_first_rel < 0) w_first_rel = i;
            end
            if (key_level[ch] && !prev && w_rise < 0) w_rise = i;
            if (!key_level[ch] && prev && w_fall < 0) w_fall = i;
            prev = key_level[ch];
            if (key_any) w_any_cnt++;
            if (key_any !== (|key_pulse)) w_any_mis++;
        end
    endtask

    // ---------------- stimulus ----------------
    int p2_bounce, lvl2_bounce, both_cnt, both_first, any_cnt;

    initial begin
        rst    = 1'b0;
        key_in = '0;
        repeat (3) tick();
        check_eq("reset_level",   32'(key_level),   32'd0);
        check_eq("reset_pulse",   32'(key_pulse),   32'd0);
        check_eq("reset_release", 32'(key_release), 32'd0);
        check_eq("reset_any",     32'(key_any),     32'd0);
        check_eq("reset_state",   32'(dbg_state),   32'd0);
        rst = 1'b1;
        repeat (5) tick();

        // Clean press on channel 1, held for 100 cycles.
        key_in[1] = 1'b1;
        watch(100, 1);
        check_eq("press_level_rise",  32'(w_rise),        32'd18);
        check_eq("press_first_pulse", 32'(w_first_pulse), 32'd19);
        check_eq("press_pulse_cnt",   32'(w_pulse_cnt),   REP_ON ? 32'd19 : 32'd1);
        check_eq("press_any_cnt",     32'(w_any_cnt),     REP_ON ? 32'd19 : 32'd1);
        check_eq("press_any_mirror",  32'(w_any_mis),     32'd0);
        check_eq("press_no_release",  32'(w_rel_cnt),     32'd0);

        // Release channel 1.
        key_in[1] = 1'b0;
        watch(40, 1);
        check_eq("rel_level_fall", 32'(w_fall),       32'd18);
        check_eq("rel_first",      32'(w_first_rel),  32'd19);
        check_eq("rel_cnt",        32'(w_rel_cnt),    32'd1);
        check_eq("rel_late_pulse", 32'(w_late_pulse), 32'd0);

        // Bounce on channel 2: runs of 5 cycles for 60 cycles, then settle at 1.
        p2_bounce = 0;
        lvl2_bounce = 0;
        for (int i = 0; i < 60; i++) begin
            key_in[2] = ((i / 5) % 2 == 0);
            tick();
            if (key_pulse[2]) p2_bounce++;
            if (key_level[2]) lvl2_bounce++;
        end
        check_eq("bounce_no_pulse", 32'(p2_bounce),   32'd0);
        check_eq("bounce_no_level", 32'(lvl2_bounce), 32'd0);
        key_in[2] = 1'b1;
        watch(40, 2);
        check_eq("bounce_settle_pulse", 32'(w_first_pulse), 32'd19);
        check_eq("bounce_pulse_cnt",    32'(w_pulse_cnt),   REP_ON ? 32'd4 : 32'd1);
        key_in[2] = 1'b0;
        watch(40, 2);
        check_eq("bounce_rel_first", 32'(w_first_rel),  32'd19);
        check_eq("bounce_rel_late",  32'(w_late_pulse), 32'd0);

        // Channels 0 and 3 pressed on the same edge.
        key_in[0] = 1'b1;
        key_in[3] = 1'b1;
        both_cnt = 0; both_first = -1; any_cnt = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (key_pulse[0] && key_pulse[3]) begin
                both_cnt++;
                if (both_first < 0) both_first = i;
            end
            if (key_any) any_cnt++;
        end
        check_eq("multi_both_cnt",   32'(both_cnt),   32'd1);
        check_eq("multi_both_first", 32'(both_first), 32'd19);
        check_eq("multi_any_cnt",    32'(any_cnt),    32'd1);

        // Reset mid-hold (channel 0 in HELD): outputs clear without a clock.
        check_eq("pre_reset_level0", 32'(key_level[0]), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("midrst_level",   32'(key_level),   32'd0);
        check_eq("midrst_pulse",   32'(key_pulse),   32'd0);
        check_eq("midrst_release", 32'(key_release), 32'd0);
        check_eq("midrst_any",     32'(key_any),     32'd0);
        check_eq("midrst_state",   32'(dbg_state),   32'd0);
        repeat (3) tick();
        check_eq("midrst_hold_pulse", 32'(key_pulse), 32'd0);
        rst = 1'b1;

        // Key still held: fresh press pulse, then repeats if compiled in.
        watch(40, 0);
        exp_q.delete();
        exp_q.push_back(32'd19);
        if (REP_ON) begin
            exp_q.push_back(32'd29);
            exp_q.push_back(32'd33);
            exp_q.push_back(32'd37);
        end
        check_eq("rearm_no_release", 32'(w_rel_cnt),    32'd0);
        check_eq("rearm_pulse_cnt",  32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check_eq("rearm_pulse_tick", got_q.pop_front(), exp_q.pop_front());
        end

        // Release channels 0 and 3.
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        watch(40, 3);
        check_eq("rel3_first", 32'(w_first_rel),  32'd19);
        check_eq("rel3_cnt",   32'(w_rel_cnt),    32'd1);
        check_eq("rel3_late",  32'(w_late_pulse), 32'd0);
        check_eq("final_level", 32'(key_level),   32'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
